// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the oversampling ratio,
// common to the parity transmitter and the parity-checking receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_parity_if.sv
// Transmit-side signal bundle: tick/request/data in, status and serial line out.
interface uart_tx_parity_if;

    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    modport master (
        output s_tick, tx_start, din,
        input  tx_busy, tx_done_tick, tx
    );

    modport slave (
        input  s_tick, tx_start, din,
        output tx_busy, tx_done_tick, tx
    );

endinterface : uart_tx_parity_if

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB first, parity bit, stop bit,
// timed by a shared 16x oversampling tick.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_parity_if.slave   bus
);

    // Tick counter must also reach SB_TICK-1 for 1.5/2 stop bits.
    localparam int unsigned S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int unsigned S_W   = $clog2(S_MAX);
    localparam int unsigned N_W   = 3;
    localparam int unsigned B_W   = 8;

    localparam logic [S_W-1:0] S_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST  = N_W'(DBIT - 1);

    uart_state_e    state_q, state_d;
    logic [S_W-1:0] s_q, s_d;
    logic [N_W-1:0] n_q, n_d;
    logic [B_W-1:0] b_q, b_d;
    logic           p_q, p_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is already IDLE; a request is not taken until the next one.
                if (bus.tx_start && !done_q) begin
                    b_d     = bus.din;
                    s_d     = '0;
                    p_d     = PARITY_ODD;
                    state_d = START;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = {1'b0, b_q[B_W-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = PARITY;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == SB_LAST) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase

        // Line level follows the state being entered so tx moves with the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_busy      = busy_q;
    assign bus.tx_done_tick = done_q;

endmodule : uart_tx_parity

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: three parameterisations share one 16-clk tick.
module tb_uart_tx_parity;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0] tcnt = '0;
    logic       tick = 1'b0;
    always @(posedge clk) begin
        tcnt <= tcnt + 4'd1;
        tick <= (tcnt == 4'd15);
    end

    uart_tx_parity_if if0 ();
    uart_tx_parity_if if1 ();
    uart_tx_parity_if if2 ();
    assign if0.s_tick = tick;
    assign if1.s_tick = tick;
    assign if2.s_tick = tick;

    uart_tx_parity u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    uart_tx_parity #(.PARITY_ODD(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    uart_tx_parity #(.DBIT(7), .SB_TICK(32)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic sel_tx, sel_busy, sel_done;
    assign sel_tx   = (sel == 0) ? if0.tx           : (sel == 1) ? if1.tx           : if2.tx;
    assign sel_busy = (sel == 0) ? if0.tx_busy      : (sel == 1) ? if1.tx_busy      : if2.tx_busy;
    assign sel_done = (sel == 0) ? if0.tx_done_tick : (sel == 1) ? if1.tx_done_tick : if2.tx_done_tick;

    // Pulse tx_start on one instance; caller is at a negedge.
    task automatic start_frame(input int idx, input logic [7:0] d);
        case (idx)
            0: begin if0.din = d; if0.tx_start = 1'b1; end
            1: begin if1.din = d; if1.tx_start = 1'b1; end
            default: begin if2.din = d; if2.tx_start = 1'b1; end
        endcase
        @(negedge clk);
        if0.tx_start = 1'b0;
        if1.tx_start = 1'b0;
        if2.tx_start = 1'b0;
    endtask

    // Tick-counting receiver on the selected line: samples each bit mid-way,
    // returns after seeing tx_done_tick.
    task automatic rx_frame(input int dbit, output logic [7:0] data, output logic par,
                            output int stop_ticks, output int busy_ticks,
                            output bit stop_low, output bit timeout);
        int  cnt;
        int  pt;
        bit  started;
        cnt = 0; started = 0; pt = 24 + 16 * dbit;
        data = '0; par = 1'b0; stop_ticks = 0; busy_ticks = 0; stop_low = 0; timeout = 1;
        for (int g = 0; g < 8000; g++) begin
            @(negedge clk);
            if (!started) begin
                if (sel_tx == 1'b0) started = 1;
                else continue;
            end
            if (sel_done) begin
                timeout = 0;
                break;
            end
            if (tick) begin
                cnt++;
                if (sel_busy) busy_ticks++;
                if (cnt >= 24 && cnt < pt && ((cnt - 24) % 16) == 0)
                    data[(cnt - 24) / 16] = sel_tx;
                if (cnt == pt) par = sel_tx;
                if (cnt > pt + 8 && sel_tx !== 1'b1) stop_low = 1;
            end
        end
        stop_ticks = cnt - pt;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #0;
            checks++;
            if (sel_tx !== 1'b1) begin failures++; $display("FAIL reset_tx inst=%0d got=%b exp=1", i, sel_tx); end
            checks++;
            if (sel_busy !== 1'b0) begin failures++; $display("FAIL reset_busy inst=%0d got=%b exp=0", i, sel_busy); end
            checks++;
            if (sel_done !== 1'b0) begin failures++; $display("FAIL reset_done inst=%0d got=%b exp=0", i, sel_done); end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] d; logic p; int st, bt; bit sl, to;
        sel = 0;
        @(negedge clk);
        fork
            start_frame(0, 8'h55);
            rx_frame(8, d, p, st, bt, sl, to);
        join
        checks++; if (to)          begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++; if (d !== 8'h55) begin failures++; $display("FAIL basic_data got=%h exp=55", d); end
        checks++; if (p !== 1'b0)  begin failures++; $display("FAIL basic_parity got=%b exp=0", p); end
        checks++; if (st != 24)    begin failures++; $display("FAIL basic_stop_ticks got=%0d exp=24", st); end
        checks++; if (bt != 176)   begin failures++; $display("FAIL basic_busy_ticks got=%0d exp=176", bt); end
        checks++; if (sl)          begin failures++; $display("FAIL basic_stop_level got=low exp=high"); end
        @(negedge clk);
        checks++; if (sel_done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b exp=0", sel_done); end
        checks++; if (sel_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", sel_busy); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_parity;
        logic [7:0] d; logic p; int st, bt; bit sl, to;
        sel = 0;
        @(negedge clk);
        fork start_frame(0, 8'h07); rx_frame(8, d, p, st, bt, sl, to); join
        checks++; if (to || d !== 8'h07) begin failures++; $display("FAIL even07_data got=%h exp=07 timeout=%0d", d, to); end
        checks++; if (p !== 1'b1) begin failures++; $display("FAIL even07_parity got=%b exp=1", p); end
        repeat (40) @(negedge clk);
        sel = 1;
        @(negedge clk);
        fork start_frame(1, 8'h07); rx_frame(8, d, p, st, bt, sl, to); join
        checks++; if (to || d !== 8'h07) begin failures++; $display("FAIL odd07_data got=%h exp=07 timeout=%0d", d, to); end
        checks++; if (p !== 1'b0) begin failures++; $display("FAIL odd07_parity got=%b exp=0", p); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_busy_rule;
        logic [7:0] d; logic p; int st, bt; bit sl, to;
        sel = 0;
        @(negedge clk);
        fork
            start_frame(0, 8'h3C);
            rx_frame(8, d, p, st, bt, sl, to);
            begin
                repeat (1500) @(negedge clk);
                if0.din = 8'hFF;
                if0.tx_start = 1'b1;
                @(negedge clk);
                if0.tx_start = 1'b0;
            end
        join
        checks++; if (to || d !== 8'h3C) begin failures++; $display("FAIL busy_ignore_data got=%h exp=3c timeout=%0d", d, to); end
        checks++; if (p !== 1'b0) begin failures++; $display("FAIL busy_ignore_parity got=%b exp=0", p); end
        repeat (40) @(negedge clk);
        checks++; if (sel_tx !== 1'b1) begin failures++; $display("FAIL busy_no_second_frame tx=%b exp=1", sel_tx); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d; logic p; int st, bt; bit sl, to; bit seen;
        sel = 0;
        @(negedge clk);
        if0.din = 8'h3C;
        if0.tx_start = 1'b1;
        rx_frame(8, d, p, st, bt, sl, to);
        checks++; if (to || d !== 8'h3C) begin failures++; $display("FAIL b2b_first_data got=%h exp=3c timeout=%0d", d, to); end
        @(negedge clk);
        checks++; if (sel_tx !== 1'b1 || sel_busy !== 1'b0)
            begin failures++; $display("FAIL b2b_done_cycle_ignored tx=%b busy=%b exp tx=1 busy=0", sel_tx, sel_busy); end
        @(negedge clk);
        checks++; if (sel_tx !== 1'b0 || sel_busy !== 1'b1)
            begin failures++; $display("FAIL b2b_restart tx=%b busy=%b exp tx=0 busy=1", sel_tx, sel_busy); end
        if0.tx_start = 1'b0;
        seen = 0;
        for (int g = 0; g < 4000 && !seen; g++) begin
            @(negedge clk);
            if (sel_done) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_second_done got=none exp=pulse"); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_loopback;
        logic [7:0] d; logic p; int st, bt; bit sl, to;
        sel = 0;
        @(negedge clk);
        fork start_frame(0, 8'hA3); rx_frame(8, d, p, st, bt, sl, to); join
        checks++; if (to || d !== 8'hA3) begin failures++; $display("FAIL loop_even_dout got=%h exp=a3 timeout=%0d", d, to); end
        checks++; if ((^d ^ p) !== 1'b0) begin failures++; $display("FAIL loop_even_error got=%b exp=0", ^d ^ p); end
        repeat (40) @(negedge clk);
        sel = 1;
        @(negedge clk);
        fork start_frame(1, 8'hA3); rx_frame(8, d, p, st, bt, sl, to); join
        checks++; if (to || d !== 8'hA3) begin failures++; $display("FAIL loop_odd_dout got=%h exp=a3 timeout=%0d", d, to); end
        checks++; if ((^d ^ p) !== 1'b1) begin failures++; $display("FAIL loop_odd_error got=%b exp=1", ^d ^ p); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_dbit7;
        logic [7:0] d; logic p; int st, bt; bit sl, to;
        sel = 2;
        @(negedge clk);
        fork start_frame(2, 8'hC1); rx_frame(7, d, p, st, bt, sl, to); join
        checks++; if (to || d !== 8'h41) begin failures++; $display("FAIL dbit7_data got=%h exp=41 timeout=%0d", d, to); end
        checks++; if (p !== 1'b0) begin failures++; $display("FAIL dbit7_parity got=%b exp=0", p); end
        checks++; if (st != 40)   begin failures++; $display("FAIL dbit7_stop_ticks got=%0d exp=40", st); end
        checks++; if (bt != 176)  begin failures++; $display("FAIL dbit7_busy_ticks got=%0d exp=176", bt); end
        checks++; if (sl)         begin failures++; $display("FAIL dbit7_stop_level got=low exp=high"); end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bad;
        sel = 0;
        @(negedge clk);
        start_frame(0, 8'h3C);
        repeat (1150) @(negedge clk);
        checks++; if (sel_busy !== 1'b1) begin failures++; $display("FAIL midreset_pre_busy got=%b exp=1", sel_busy); end
        reset = 1'b1;
        #1;
        checks++; if (sel_tx !== 1'b1)   begin failures++; $display("FAIL midreset_async_tx got=%b exp=1", sel_tx); end
        checks++; if (sel_busy !== 1'b0) begin failures++; $display("FAIL midreset_async_busy got=%b exp=0", sel_busy); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int g = 0; g < 1000; g++) begin
            @(negedge clk);
            if (sel_tx !== 1'b1 || sel_busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midreset_idle_after got=%0d_bad_cycles exp=0", bad); end
    endtask

    initial begin
        reset = 1'b1;
        if0.tx_start = 1'b0; if0.din = '0;
        if1.tx_start = 1'b0; if1.din = '0;
        if2.tx_start = 1'b0; if2.din = '0;
        test_reset();
        test_basic();
        test_parity();
        test_busy_rule();
        test_back_to_back();
        test_loopback();
        test_dbit7();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_parity
